// File: rtl/whistle_command_decoder.sv
// Whistle command decoder.
// Turns the per-frame pitch stream from the pitch detector into command pulses:
// hot frames are debounced into tones, each tone is graded short/long and the
// first tone is graded flat/rising/falling, and a run of tones closed by
// silence (or by reaching the tone limit) is emitted as one command.
module whistle_command_decoder #(
  parameter int NSamples       = 256,
  parameter int THRESHOLD      = 50,
  parameter int MIN_FRAMES     = 3,
  parameter int GAP_FRAMES     = 2,
  parameter int LONG_FRAMES    = 12,
  parameter int TIMEOUT_FRAMES = 8,
  parameter int SWEEP_DELTA    = 8,
  parameter int MAX_TONES      = 4,
  localparam int BW            = $clog2(NSamples)
) (
  input  logic                 fft_clk,
  input  logic                 reset,
  input  logic [BW-1:0]        pitch_data,
  input  logic                 pitch_valid,
  input  logic                 flush,
  output logic                 tone_active,
  output logic                 cmd_valid,
  output logic [2:0]           cmd_len,
  output logic [MAX_TONES-1:0] cmd_pattern,
  output logic [1:0]           cmd_sweep
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ONSET   = 3'd1;
  localparam logic [2:0] TONE    = 3'd2;
  localparam logic [2:0] RELEASE = 3'd3;
  localparam logic [2:0] GAP     = 3'd4;

  localparam logic [1:0] SWEEP_FLAT    = 2'b00;
  localparam logic [1:0] SWEEP_RISING  = 2'b01;
  localparam logic [1:0] SWEEP_FALLING = 2'b10;

  localparam logic [BW-1:0]        THRESH_BIN  = BW'(THRESHOLD);
  localparam logic [7:0]           MIN_LEN     = 8'(MIN_FRAMES);
  localparam logic [7:0]           GAP_LEN     = 8'(GAP_FRAMES);
  localparam logic [7:0]           LONG_LEN    = 8'(LONG_FRAMES);
  localparam logic [7:0]           TIMEOUT_LEN = 8'(TIMEOUT_FRAMES);
  localparam logic [BW:0]          DELTA       = (BW+1)'(SWEEP_DELTA);
  localparam logic [2:0]           TONE_LIMIT  = 3'(MAX_TONES);
  localparam logic [MAX_TONES-1:0] PAT_ONE     = MAX_TONES'(1);

  logic [2:0]           state;
  logic [7:0]           len;
  logic [7:0]           cold_cnt;
  logic [7:0]           gap_cnt;
  logic [2:0]           tone_count;
  logic [BW-1:0]        start_bin;
  logic [BW-1:0]        last_bin;
  logic [MAX_TONES-1:0] pattern_acc;
  logic [1:0]           sweep_reg;

  logic                 frame_hot;
  logic [7:0]           len_next;
  logic [2:0]           tone_count_next;
  logic [MAX_TONES-1:0] pattern_next;
  logic [1:0]           sweep_now;
  logic [1:0]           sweep_next;
  logic [BW:0]          start_ext;
  logic [BW:0]          last_ext;

  // Frame classification and the values a tone end would commit this frame
  always_comb begin
    frame_hot       = pitch_data > THRESH_BIN;
    len_next        = (len == 8'hFF) ? len : len + 8'd1;
    tone_count_next = tone_count + 3'd1;
    pattern_next    = pattern_acc;
    if (len >= LONG_LEN) begin
      pattern_next = pattern_acc | (PAT_ONE << tone_count);
    end
    start_ext = {1'b0, start_bin};
    last_ext  = {1'b0, last_bin};
    sweep_now = SWEEP_FLAT;
    if (last_ext >= start_ext + DELTA) begin
      sweep_now = SWEEP_RISING;
    end else if (start_ext >= last_ext + DELTA) begin
      sweep_now = SWEEP_FALLING;
    end
    sweep_next = (tone_count == 3'd0) ? sweep_now : sweep_reg;
  end

  // Per-frame tone tracking FSM with command emission
  always_ff @(posedge fft_clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      len         <= 8'd0;
      cold_cnt    <= 8'd0;
      gap_cnt     <= 8'd0;
      tone_count  <= 3'd0;
      start_bin   <= '0;
      last_bin    <= '0;
      pattern_acc <= '0;
      sweep_reg   <= SWEEP_FLAT;
      tone_active <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_len     <= 3'd0;
      cmd_pattern <= '0;
      cmd_sweep   <= 2'b00;
    end else begin
      cmd_valid <= 1'b0;
      if (flush) begin
        state       <= IDLE;
        len         <= 8'd0;
        cold_cnt    <= 8'd0;
        gap_cnt     <= 8'd0;
        tone_count  <= 3'd0;
        pattern_acc <= '0;
        sweep_reg   <= SWEEP_FLAT;
        tone_active <= 1'b0;
      end else if (pitch_valid) begin
        case (state)
          IDLE, GAP: begin
            if (frame_hot) begin
              state     <= ONSET;
              len       <= 8'd1;
              start_bin <= pitch_data;
              last_bin  <= pitch_data;
              if (MIN_LEN <= 8'd1) begin
                state       <= TONE;
                tone_active <= 1'b1;
              end
            end else if (state == GAP) begin
              if ((gap_cnt + 8'd1 >= TIMEOUT_LEN) && (tone_count != 3'd0)) begin
                cmd_valid   <= 1'b1;
                cmd_len     <= tone_count;
                cmd_pattern <= pattern_acc;
                cmd_sweep   <= sweep_reg;
                pattern_acc <= '0;
                tone_count  <= 3'd0;
                gap_cnt     <= 8'd0;
                state       <= IDLE;
              end else begin
                gap_cnt <= gap_cnt + 8'd1;
              end
            end
          end
          ONSET: begin
            if (frame_hot) begin
              len      <= len_next;
              last_bin <= pitch_data;
              if (len_next >= MIN_LEN) begin
                state       <= TONE;
                tone_active <= 1'b1;
              end
            end else begin
              // A glitch: the partial tone is dropped and gap timing resumes
              len   <= 8'd0;
              state <= (tone_count != 3'd0) ? GAP : IDLE;
            end
          end
          TONE: begin
            if (frame_hot) begin
              len      <= len_next;
              last_bin <= pitch_data;
            end else begin
              state    <= RELEASE;
              cold_cnt <= 8'd1;
            end
          end
          RELEASE: begin
            if (frame_hot) begin
              state    <= TONE;
              len      <= len_next;
              last_bin <= pitch_data;
              cold_cnt <= 8'd0;
            end else if (cold_cnt + 8'd1 >= GAP_LEN) begin
              tone_active <= 1'b0;
              cold_cnt    <= 8'd0;
              len         <= 8'd0;
              sweep_reg   <= sweep_next;
              if (tone_count_next == TONE_LIMIT) begin
                cmd_valid   <= 1'b1;
                cmd_len     <= tone_count_next;
                cmd_pattern <= pattern_next;
                cmd_sweep   <= sweep_next;
                pattern_acc <= '0;
                tone_count  <= 3'd0;
                state       <= IDLE;
              end else begin
                pattern_acc <= pattern_next;
                tone_count  <= tone_count_next;
                gap_cnt     <= 8'd0;
                state       <= GAP;
              end
            end else begin
              cold_cnt <= cold_cnt + 8'd1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_whistle_command_decoder.sv
// Testbench for whistle_command_decoder: directed scenarios with fixed expected
// values, then randomized frame streams checked against a run-length model.
module tb_whistle_command_decoder;

  localparam int TH      = 50;
  localparam int MINF    = 3;
  localparam int GAPF    = 2;
  localparam int LONGF   = 12;
  localparam int TOUTF   = 8;
  localparam int DELTA   = 8;
  localparam int MAXT    = 4;

  logic       fft_clk = 1'b0;
  logic       reset;
  logic [7:0] pitch_data;
  logic       pitch_valid;
  logic       flush;
  logic       tone_active;
  logic       cmd_valid;
  logic [2:0] cmd_len;
  logic [3:0] cmd_pattern;
  logic [1:0] cmd_sweep;

  int checks   = 0;
  int failures = 0;

  // Reference model state: a candidate tone, whether it is confirmed, and
  // the tones gathered so far in the current command.
  bit m_cand, m_conf;
  int m_tlen, m_sb, m_lb, m_cold_run, m_tones, m_since, m_pat, m_swp;
  bit e_valid;
  int e_len, e_pat, e_swp;

  whistle_command_decoder dut (
    .fft_clk     (fft_clk),
    .reset       (reset),
    .pitch_data  (pitch_data),
    .pitch_valid (pitch_valid),
    .flush       (flush),
    .tone_active (tone_active),
    .cmd_valid   (cmd_valid),
    .cmd_len     (cmd_len),
    .cmd_pattern (cmd_pattern),
    .cmd_sweep   (cmd_sweep)
  );

  // Free-running frame-domain clock
  always #5 fft_clk = ~fft_clk;

  // Hard stop if the bench ever stalls
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic model_reset();
    m_cand = 0; m_conf = 0; m_tlen = 0; m_sb = 0; m_lb = 0; m_cold_run = 0;
    m_tones = 0; m_since = 0; m_pat = 0; m_swp = 0;
    e_valid = 0; e_len = 0; e_pat = 0; e_swp = 0;
  endtask

  task automatic model_emit();
    e_valid = 1; e_len = m_tones; e_pat = m_pat; e_swp = m_swp;
    m_tones = 0; m_pat = 0; m_since = 0;
  endtask

  task automatic model_frame(input int bin, input bit fl);
    e_valid = 0;
    if (fl) begin
      m_cand = 0; m_conf = 0; m_tones = 0; m_pat = 0; m_tlen = 0;
      m_since = 0; m_cold_run = 0;
    end else if (bin > TH) begin
      if (!m_cand) begin
        m_cand = 1; m_tlen = 1; m_sb = bin; m_lb = bin; m_conf = (MINF <= 1);
      end else begin
        if (m_tlen < 255) m_tlen++;
        m_lb = bin;
        if (m_tlen >= MINF) m_conf = 1;
      end
      m_cold_run = 0;
    end else begin
      if (m_cand && !m_conf) begin
        m_cand = 0;
      end else if (m_cand) begin
        m_cold_run++;
        if (m_cold_run >= GAPF) begin
          if (m_tones == 0)
            m_swp = (m_lb >= m_sb + DELTA) ? 1 : ((m_sb >= m_lb + DELTA) ? 2 : 0);
          if (m_tlen >= LONGF) m_pat |= (1 << m_tones);
          m_tones++; m_cand = 0; m_conf = 0; m_cold_run = 0; m_since = 0;
          if (m_tones == MAXT) model_emit();
        end
      end else if (m_tones > 0) begin
        m_since++;
        if (m_since >= TOUTF) model_emit();
      end
    end
  endtask

  // One frame: pitch_valid for a cycle, outputs observed on the next falling edge
  task automatic drive_frame(input int bin, input bit fl);
    @(negedge fft_clk);
    pitch_data  = 8'(bin);
    pitch_valid = 1'b1;
    flush       = fl;
    @(negedge fft_clk);
    pitch_valid = 1'b0;
    flush       = 1'b0;
    model_frame(bin, fl);
  endtask

  task automatic do_reset();
    reset = 1'b1; pitch_valid = 1'b0; flush = 1'b0; pitch_data = 8'd0;
    repeat (2) @(negedge fft_clk);
    reset = 1'b0;
    model_reset();
    @(negedge fft_clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({tone_active, cmd_valid, cmd_len, cmd_pattern, cmd_sweep} !== 11'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got act=%0b val=%0b len=%0d pat=%b sw=%b required all 0",
               tone_active, cmd_valid, cmd_len, cmd_pattern, cmd_sweep);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int k = 1; k <= 22; k++) begin
      drive_frame((k <= 2) ? 60 : 10, 1'b0);
      checks++;
      if (tone_active !== 1'b0 || cmd_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL glitch frame %0d: got act=%0b val=%0b required 0 0", k, tone_active, cmd_valid);
      end
    end
  endtask

  task automatic test_short_tone();
    do_reset();
    for (int k = 1; k <= 15; k++) begin
      drive_frame((k <= 5) ? 60 : 10, 1'b0);
      checks++;
      if (tone_active !== (k >= 3 && k <= 6) || cmd_valid !== (k == 15)) begin
        failures++;
        $display("[TB] FAIL short_tone frame %0d: got act=%0b val=%0b required %0b %0b",
                 k, tone_active, cmd_valid, (k >= 3 && k <= 6), (k == 15));
      end
    end
    checks++;
    if (cmd_len !== 3'd1 || cmd_pattern !== 4'b0000 || cmd_sweep !== 2'b00) begin
      failures++;
      $display("[TB] FAIL short_tone_cmd: got len=%0d pat=%b sw=%b required 1 0000 00", cmd_len, cmd_pattern, cmd_sweep);
    end
  endtask

  task automatic test_sweep(input bit rising);
    int bin;
    logic [1:0] want;
    want = rising ? 2'b01 : 2'b10;
    do_reset();
    for (int k = 1; k <= 25; k++) begin
      if (k <= 15) begin
        bin = (k == 15) ? 70 : 55 + (k - 1);
        if (!rising) bin = 125 - bin;
      end else begin
        bin = 10;
      end
      drive_frame(bin, 1'b0);
      checks++;
      if (tone_active !== (k >= 3 && k <= 16) || cmd_valid !== (k == 25)) begin
        failures++;
        $display("[TB] FAIL sweep%0b frame %0d: got act=%0b val=%0b", rising, k, tone_active, cmd_valid);
      end
    end
    checks++;
    if (cmd_len !== 3'd1 || cmd_pattern !== 4'b0001 || cmd_sweep !== want) begin
      failures++;
      $display("[TB] FAIL sweep%0b_cmd: got len=%0d pat=%b sw=%b required 1 0001 %b",
               rising, cmd_len, cmd_pattern, cmd_sweep, want);
    end
  endtask

  task automatic test_dropout();
    int emits;
    do_reset();
    for (int k = 1; k <= 3; k++) drive_frame(TH, 1'b0);
    checks++;
    if (tone_active !== 1'b0) begin
      failures++;
      $display("[TB] FAIL threshold_cold: got act=%0b required 0 for bin %0d", tone_active, TH);
    end
    do_reset();
    emits = 0;
    for (int k = 1; k <= 23; k++) begin
      drive_frame((k <= 4 || (k >= 6 && k <= 13)) ? TH + 1 : TH, 1'b0);
      if (cmd_valid) emits++;
      if (k == 5) begin
        checks++;
        if (tone_active !== 1'b1) begin
          failures++;
          $display("[TB] FAIL dropout_bridge: got act=%0b required 1", tone_active);
        end
      end
    end
    checks++;
    if (emits !== 1 || cmd_valid !== 1'b1 || cmd_len !== 3'd1 || cmd_pattern !== 4'b0001 || cmd_sweep !== 2'b00) begin
      failures++;
      $display("[TB] FAIL dropout_cmd: got emits=%0d val=%0b len=%0d pat=%b sw=%b required 1 1 1 0001 00",
               emits, cmd_valid, cmd_len, cmd_pattern, cmd_sweep);
    end
  endtask

  task automatic test_max_tones();
    int lens[4] = '{4, 13, 4, 13};
    int fr, emits, emit_fr;
    logic [2:0] got_len;
    logic [3:0] got_pat;
    do_reset();
    fr = 0; emits = 0; emit_fr = -1; got_len = 0; got_pat = 0;
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < lens[t] + 3; k++) begin
        drive_frame((k < lens[t]) ? 60 : 10, 1'b0);
        fr++;
        if (cmd_valid) begin
          emits++; emit_fr = fr; got_len = cmd_len; got_pat = cmd_pattern;
        end
      end
    end
    checks++;
    if (emits !== 1 || emit_fr !== 45 || got_len !== 3'd4 || got_pat !== 4'b1010) begin
      failures++;
      $display("[TB] FAIL max_tones: got emits=%0d frame=%0d len=%0d pat=%b required 1 45 4 1010",
               emits, emit_fr, got_len, got_pat);
    end
    emits = 0;
    for (int k = 1; k <= 13; k++) begin
      drive_frame((k <= 3) ? 60 : 10, 1'b0);
      if (cmd_valid) emits++;
      if (k == 1 || k == 3) begin
        checks++;
        if (tone_active !== (k == 3)) begin
          failures++;
          $display("[TB] FAIL fresh_onset frame %0d: got act=%0b required %0b", k, tone_active, (k == 3));
        end
      end
    end
    checks++;
    if (emits !== 1 || cmd_len !== 3'd1 || cmd_pattern !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL after_max_cmd: got emits=%0d len=%0d pat=%b required 1 1 0000", emits, cmd_len, cmd_pattern);
    end
  endtask

  task automatic test_flush();
    int emits;
    do_reset();
    for (int k = 1; k <= 7; k++) drive_frame((k <= 5) ? 60 : 10, 1'b0);
    for (int k = 1; k <= 6; k++) drive_frame(60, 1'b0);
    checks++;
    if (tone_active !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flush_pre: got act=%0b required 1", tone_active);
    end
    drive_frame(60, 1'b1);
    checks++;
    if (tone_active !== 1'b0 || cmd_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_now: got act=%0b val=%0b required 0 0", tone_active, cmd_valid);
    end
    emits = 0;
    for (int k = 1; k <= 12; k++) begin
      drive_frame(10, 1'b0);
      if (cmd_valid) emits++;
    end
    checks++;
    if (emits !== 0) begin
      failures++;
      $display("[TB] FAIL flush_no_cmd: got %0d commands required 0", emits);
    end
  endtask

  task automatic test_reset_mid_gap();
    int emits;
    do_reset();
    for (int k = 1; k <= 15; k++) drive_frame((k <= 5) ? 60 : 10, 1'b0);
    for (int k = 1; k <= 8; k++) drive_frame((k <= 5) ? 60 : 10, 1'b0);
    for (int k = 1; k <= 7; k++) drive_frame((k <= 5) ? 60 : 10, 1'b0);
    checks++;
    if (cmd_len !== 3'd1) begin
      failures++;
      $display("[TB] FAIL hold_before_reset: got len=%0d required 1", cmd_len);
    end
    reset = 1'b1;
    #2;
    checks++;
    if ({tone_active, cmd_valid, cmd_len, cmd_pattern, cmd_sweep} !== 11'd0) begin
      failures++;
      $display("[TB] FAIL async_reset: got act=%0b val=%0b len=%0d pat=%b sw=%b required all 0",
               tone_active, cmd_valid, cmd_len, cmd_pattern, cmd_sweep);
    end
    @(negedge fft_clk);
    reset = 1'b0;
    model_reset();
    emits = 0;
    for (int k = 1; k <= 12; k++) begin
      drive_frame(10, 1'b0);
      if (cmd_valid) emits++;
    end
    checks++;
    if (emits !== 0) begin
      failures++;
      $display("[TB] FAIL reset_no_cmd: got %0d commands required 0", emits);
    end
  endtask

  task automatic test_random();
    int hot_len, cold_len, base, slope, bin, model_emits;
    bit fl;
    do_reset();
    model_emits = 0;
    for (int run = 0; run < 80; run++) begin
      hot_len  = $urandom_range(16, 3);
      cold_len = $urandom_range(12, 1);
      base     = $urandom_range(200, 51);
      slope    = int'($urandom_range(4, 0)) - 2;
      for (int k = 0; k < hot_len + cold_len; k++) begin
        if (k < hot_len) begin
          bin = base + slope * k;
          if (bin < TH + 1) bin = TH + 1;
          if (bin > 255) bin = 255;
          fl = ($urandom_range(39, 0) == 0);
        end else begin
          bin = ($urandom_range(3, 0) == 0) ? TH : $urandom_range(TH, 0);
          fl  = 1'b0;
        end
        drive_frame(bin, fl);
        if (e_valid) model_emits++;
        checks++;
        if (tone_active !== m_conf || cmd_valid !== e_valid || cmd_len !== 3'(e_len) ||
            cmd_pattern !== 4'(e_pat) || cmd_sweep !== 2'(e_swp)) begin
          failures++;
          $display("[TB] FAIL random run %0d frame %0d: got act=%0b val=%0b len=%0d pat=%b sw=%b required %0b %0b %0d %b %b",
                   run, k, tone_active, cmd_valid, cmd_len, cmd_pattern, cmd_sweep,
                   m_conf, e_valid, e_len, 4'(e_pat), 2'(e_swp));
        end
        repeat ($urandom_range(2, 0)) begin
          @(negedge fft_clk);
          checks++;
          if (cmd_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL random_idle run %0d: got val=%0b required 0", run, cmd_valid);
          end
        end
      end
    end
    $display("[TB] random stimulus produced %0d expected commands", model_emits);
  endtask

  // Scenario sequence
  initial begin
    reset = 1'b1; pitch_valid = 1'b0; flush = 1'b0; pitch_data = 8'd0;
    model_reset();
    test_reset();
    test_glitch();
    test_short_tone();
    test_sweep(1'b1);
    test_sweep(1'b0);
    test_dropout();
    test_max_tones();
    test_flush();
    test_reset_mid_gap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/whistle_command_decoder.md
Name: whistle_command_decoder

Overview:
Consumes the per-frame pitch stream (one bin index per FFT frame) from the pitch detector and decodes whistle sequences into commands. Each frame is classified hot or cold. Hot runs are debounced into tones, and each tone is measured (short/long, flat/rising/falling). A sequence of 1..MAX_TONES tones followed by silence is emitted as one command pulse. Sits in the fft_clk domain directly downstream of the pitch detector outputs.

Parameters:
NSamples, 256, FFT length; bin index width is BW = $clog2(NSamples)
THRESHOLD, 50, a frame is hot iff pitch_data > THRESHOLD (strict)
MIN_FRAMES, 3, consecutive hot frames needed to confirm a tone
GAP_FRAMES, 2, consecutive cold frames that end a tone
LONG_FRAMES, 12, tone length (in hot frames) at or above which a tone is long
TIMEOUT_FRAMES, 8, cold frames after a tone end that close the sequence
SWEEP_DELTA, 8, bin difference needed to classify the first tone as rising or falling
MAX_TONES, 4, maximum tones per command

Ports:
fft_clk  in  1  clock
reset  in  1  asynchronous, active-high
pitch_data  in  BW  peak bin index, sampled only when pitch_valid=1
pitch_valid  in  1  one-cycle pulse per frame
flush  in  1  synchronous abort of the current sequence
tone_active  out  1  level, high while a confirmed tone is in progress
cmd_valid  out  1  one-cycle command pulse
cmd_len  out  3  number of tones in the command, 1..MAX_TONES
cmd_pattern  out  MAX_TONES  bit i = 1 if tone i is long; unused bits 0
cmd_sweep  out  2  first tone sweep: 00 flat, 01 rising, 10 falling

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters and registers cleared.
- Frame events are evaluated only on cycles where pitch_valid=1. All state updates and outputs are registered and appear on the cycle after that pitch_valid.
- flush=1 forces IDLE, clears tone_count, len, cold_cnt and gap_cnt, and drives tone_active=0 with no command emitted. If flush and pitch_valid arrive in the same cycle, flush wins and the frame is discarded.
- Internal registers:
  - len: 8-bit, saturates at 255.
  - cold_cnt, gap_cnt: frame counters.
  - tone_count: 0..MAX_TONES.
  - start_bin, last_bin: BW bits each.
  - pattern accumulator.
  - sweep register.
- FSM, per frame:
  - IDLE:
    - hot: go to ONSET; len=1; start_bin=last_bin=pitch_data.
    - cold: stay.
  - ONSET:
    - hot: len++; last_bin=pitch_data. When len reaches MIN_FRAMES, go to TONE with tone_active=1.
    - cold: glitch. Return to GAP if tone_count>0, otherwise IDLE. len is discarded. If returning to GAP, gap_cnt continues counting from its prior value and does not restart.
  - TONE:
    - hot: len++; last_bin=pitch_data.
    - cold: go to RELEASE with cold_cnt=1.
  - RELEASE:
    - hot: go to TONE; len++; last_bin updated; cold_cnt=0. Cold frames are not added to len.
    - cold: cold_cnt++. When cold_cnt reaches GAP_FRAMES, the tone ends (see tone end below).
  - GAP:
    - hot: go to ONSET; len=1; start_bin=last_bin=pitch_data.
    - cold: gap_cnt++. When gap_cnt reaches TIMEOUT_FRAMES, emit and go to IDLE.
- Tone end (on the RELEASE cold frame that reaches GAP_FRAMES):
  - tone_active=0.
  - pattern[tone_count] = (len >= LONG_FRAMES).
  - If tone_count==0, record the sweep:
    - rising if last_bin >= start_bin + SWEEP_DELTA;
    - falling if start_bin >= last_bin + SWEEP_DELTA;
    - else flat.
    - Use unsigned arithmetic with BW+1 bits so the comparison cannot wrap.
  - tone_count++.
  - If tone_count is now MAX_TONES, emit immediately and go to IDLE. Otherwise go to GAP with gap_cnt=0.
- Emit: cmd_valid=1 for exactly one cycle, with cmd_len=tone_count, cmd_pattern=accumulator, cmd_sweep=sweep register.
  - cmd_* outputs hold their values until the next emit.
  - After an emit, the accumulator and tone_count are cleared.
  - Emission requires tone_count>=1; a command with zero tones is never emitted.
  - No back-pressure; the consumer must sample on cmd_valid.
- Threshold boundary: bin == THRESHOLD is cold; THRESHOLD+1 is hot.
- Latency: exactly 1 fft_clk after the triggering pitch_valid.

Test Plan:
- Glitch rejection: reset, then 2 hot frames (bin 60) followed by 20 cold frames (bin 10) -> tone_active stays 0, no cmd_valid.
- Single short tone: 5 hot frames (bin 60), then 10 cold frames -> tone_active rises after the 3rd hot frame and falls after the 2nd cold frame; cmd_valid after the 10th cold frame with cmd_len=1, cmd_pattern=0000, cmd_sweep=00.
- Long rising tone: 15 hot frames with bins 55→70, then 10 cold frames -> cmd_len=1, cmd_pattern=0001, cmd_sweep=01. Repeat with 70→55 -> cmd_sweep=10.
- Dropout bridging and threshold edge: 4 hot (bin 51), 1 cold (bin 50), 8 hot, then 10 cold -> one tone of len 12 -> cmd_len=1, cmd_pattern=0001.
- Max tones: four tones of lengths 4, 13, 4, 13 separated by 3 cold frames each -> cmd_valid at the end of the 4th tone with no timeout wait; cmd_len=4, cmd_pattern=1010. A following hot frame starts a fresh ONSET.
- Flush/reset mid-tone: 6 hot frames, then flush coincident with a pitch_valid -> tone_active=0 next cycle and no cmd_valid. Asserting reset mid-GAP with tone_count=2 -> all outputs 0 immediately, and a subsequent timeout emits nothing.
